// File: rtl/cim_pkg.sv
// Shared types and helpers for the bit-serial CIM accumulator slice.
// Holds the FSM encoding, the accumulator-width legality check and the bus packing rule.
package cim_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // The accumulator must hold the psum plus IN_BITS doublings, so it can never overflow.
  function automatic bit acc_width_ok(input int acc_w, input int psum_w, input int in_bits);
    return acc_w >= (psum_w + in_bits);
  endfunction

  function automatic int pack_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cim_shift_acc_lane.sv
// One channel of the MSB-first shift-add engine.
// The first beat loads the sign-extended psum (negated for a signed activation MSB); later beats double and add.
module cim_shift_acc_lane
  import cim_pkg::*;
#(
  parameter int PSUM_WIDTH = 27,
  parameter int ACC_WIDTH  = 51
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic                  i_first,
  input  logic                  i_neg,
  input  logic [PSUM_WIDTH-1:0] i_psum,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_next;

  assign w_ext = {{(ACC_WIDTH-PSUM_WIDTH){i_psum[PSUM_WIDTH-1]}}, i_psum};

  always_comb begin
    w_next = r_acc;
    if (i_first) begin
      w_next = i_neg ? (-w_ext) : w_ext;
    end else begin
      w_next = (r_acc << 1) + w_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cim_bitserial_accumulator.sv
// Multi-channel bit-serial shift-accumulate engine between global I/O psums and the macro output bus.
// A one-deep result buffer lets the next operation run while the previous result waits to drain.
module cim_bitserial_accumulator
  import cim_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int PSUM_WIDTH = 27,
  parameter int IN_BITS    = 8,
  parameter int ACC_WIDTH  = 51,
  parameter int BIDX_W     = $clog2(IN_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      start_ready,
  input  logic                      signed_op,
  output logic [BIDX_W-1:0]         bit_idx,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [NCH*PSUM_WIDTH-1:0] psum_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NCH*ACC_WIDTH-1:0]  nout,
  output logic                      busy
);

  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(IN_BITS - 1);

  if (!acc_width_ok(ACC_WIDTH, PSUM_WIDTH, IN_BITS)) begin : g_bad_cfg
    $error("cim_bitserial_accumulator: ACC_WIDTH must be at least PSUM_WIDTH+IN_BITS");
  end

  state_e                     r_state;
  state_e                     w_state_next;
  logic [BIDX_W-1:0]          r_beat_cnt;
  logic [BIDX_W-1:0]          r_bit_idx;
  logic                       r_signed;
  logic                       r_out_valid;
  logic [NCH*ACC_WIDTH-1:0]   r_nout;
  logic [NCH*ACC_WIDTH-1:0]   w_acc;
  logic                       w_start_ok;
  logic                       w_beat;
  logic                       w_first;
  logic                       w_last;
  logic                       w_load;

  assign w_first    = (r_beat_cnt == '0);
  assign w_last     = (r_beat_cnt == LAST_IDX);
  assign w_start_ok = start_ready && start;
  assign w_beat     = psum_valid && psum_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DRAIN may load the buffer when it is empty or being emptied by the same-cycle handshake.
  always_comb begin
    w_state_next = r_state;
    start_ready  = 1'b0;
    psum_ready   = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start) begin
          w_state_next = ST_ACC;
        end
      end
      ST_ACC: begin
        psum_ready = 1'b1;
        if (psum_valid && w_last) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_out_valid || out_ready) begin
          w_load       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_bit_idx  <= LAST_IDX;
      r_signed   <= 1'b0;
    end else if (w_start_ok) begin
      r_beat_cnt <= '0;
      r_bit_idx  <= LAST_IDX;
      r_signed   <= signed_op;
    end else if (w_beat) begin
      r_beat_cnt <= w_last ? '0 : (r_beat_cnt + 1'b1);
      if (r_bit_idx != '0) begin
        r_bit_idx <= r_bit_idx - 1'b1;
      end
    end
  end

  // A refill in the same cycle as a handshake wins, so out_valid never drops between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_nout      <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_nout      <= w_acc;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    cim_shift_acc_lane #(
      .PSUM_WIDTH(PSUM_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clear(w_start_ok),
      .i_en   (w_beat),
      .i_first(w_first),
      .i_neg  (r_signed),
      .i_psum (psum_in[pack_lsb(c, PSUM_WIDTH) +: PSUM_WIDTH]),
      .o_acc  (w_acc[pack_lsb(c, ACC_WIDTH) +: ACC_WIDTH])
    );
  end

  assign bit_idx   = r_bit_idx;
  assign out_valid = r_out_valid;
  assign nout      = r_nout;
  assign busy      = (r_state != ST_IDLE) || r_out_valid;

endmodule

// File: tb/tb_cim_bitserial_accumulator.sv
// Directed self-checking bench for cim_bitserial_accumulator (NCH=4, IN_BITS=8).
// Inputs change and outputs are sampled on the falling clock edge, away from the active edge.
module tb_cim_bitserial_accumulator;

  localparam int NCH = 4;
  localparam int PW  = 27;
  localparam int IB  = 8;
  localparam int AW  = 51;
  localparam int BW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              start_ready;
  logic              signed_op;
  logic [BW-1:0]     bit_idx;
  logic              psum_valid;
  logic              psum_ready;
  logic [NCH*PW-1:0] psum_in;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*AW-1:0] nout;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic signed [PW-1:0] bv [IB][NCH];
  logic signed [63:0]   ev [NCH];

  cim_bitserial_accumulator #(
    .NCH(NCH), .PSUM_WIDTH(PW), .IN_BITS(IB), .ACC_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_ready(start_ready),
    .signed_op  (signed_op),
    .bit_idx    (bit_idx),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_in    (psum_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .nout       (nout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] lane(input int c);
    logic signed [AW-1:0] v;
    v = nout[c*AW +: AW];
    return v;
  endfunction

  task automatic checkLanes(input string tag);
    for (int c = 0; c < NCH; c++) begin
      checkOutput($sformatf("%s_ch%0d", tag, c), lane(c), ev[c]);
    end
  endtask

  task automatic fillAll(input logic signed [PW-1:0] v);
    for (int k = 0; k < IB; k++)
      for (int c = 0; c < NCH; c++)
        bv[k][c] = v;
  endtask

  task automatic setExp(input logic signed [63:0] v);
    for (int c = 0; c < NCH; c++) ev[c] = v;
  endtask

  task automatic drainResult();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Starts an operation, toggles signed_op during the beats, and ends one cycle after the last beat.
  task automatic applyStimulus(input string tag, input bit sgn, input int gapAfter, input int gapLen);
    int n;
    n = 0;
    while (!start_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_start_ready"}, start_ready, 1);
    start     = 1'b1;
    signed_op = sgn;
    tick();
    start     = 1'b0;
    signed_op = ~sgn;
    for (int k = 0; k < IB; k++) begin
      for (int c = 0; c < NCH; c++) psum_in[c*PW +: PW] = bv[k][c];
      psum_valid = 1'b1;
      checkOutput($sformatf("%s_bit_idx%0d", tag, k), bit_idx, IB - 1 - k);
      tick();
      if (gapLen > 0 && k == gapAfter - 1) begin
        psum_valid = 1'b0;
        psum_in    = '1;
        repeat (gapLen) tick();
        checkOutput({tag, "_gap_ready"}, psum_ready, 1);
        checkOutput({tag, "_gap_bit_idx"}, bit_idx, IB - 2 - k);
      end
    end
    psum_valid = 1'b0;
    signed_op  = 1'b0;
  endtask

  task automatic checkLatency(input string tag);
    checkOutput({tag, "_lat_n1"}, out_valid, 0);
    checkOutput({tag, "_bit_idx_hold"}, bit_idx, 0);
    tick();
    checkOutput({tag, "_lat_n2"}, out_valid, 1);
    checkLanes(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    signed_op  = 1'b0;
    psum_valid = 1'b0;
    psum_in    = '0;
    out_ready  = 1'b0;
    repeat (2) tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_nout", (nout == '0), 1);
    checkOutput("rst_bit_idx", bit_idx, 7);
    checkOutput("rst_psum_ready", psum_ready, 0);
    checkOutput("rst_start_ready", start_ready, 1);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] unsigned all-ones");
    fillAll(1);
    setExp(255);
    applyStimulus("ones", 1'b0, 0, 0);
    checkOutput("ones_busy_drain", busy, 1);
    checkLatency("ones");
    drainResult();
    checkOutput("ones_drained", out_valid, 0);
    checkOutput("ones_idle_busy", busy, 0);

    $display("[TB] signed MSB one");
    fillAll(0);
    bv[0] = '{1, 1, 1, 1};
    setExp(-128);
    applyStimulus("smsb", 1'b1, 0, 0);
    checkLatency("smsb");
    drainResult();

    $display("[TB] signed MSB minus three");
    fillAll(0);
    bv[0] = '{-3, -3, -3, -3};
    setExp(384);
    applyStimulus("sm3", 1'b1, 0, 0);
    checkLatency("sm3");
    drainResult();

    $display("[TB] per-channel pattern, no gap");
    psum_valid = 1'b1;
    psum_in    = '1;
    tick();
    checkOutput("idle_not_consumed", psum_ready, 0);
    for (int k = 0; k < IB; k++) begin
      bv[k][0] = (k == 0 || k == 2 || k == 3 || k == 6) ? 1 : 0;
      bv[k][1] = 5;
      bv[k][2] = -1;
      bv[k][3] = (k == 0) ? 3 : 0;
    end
    ev = '{178, 1275, -255, 384};
    applyStimulus("pat", 1'b0, 0, 0);
    checkLatency("pat");
    drainResult();

    $display("[TB] per-channel pattern, gap after beat 2");
    applyStimulus("gap", 1'b0, 2, 3);
    checkLatency("gap");
    drainResult();

    $display("[TB] back-pressure overlap");
    fillAll(1);
    setExp(255);
    applyStimulus("bpA", 1'b0, 0, 0);
    checkLatency("bpA");
    checkOutput("bp_overlap_ready", start_ready, 1);
    checkOutput("bp_overlap_busy", busy, 1);
    fillAll(2);
    applyStimulus("bpB", 1'b0, 0, 0);
    checkOutput("bp_held_valid", out_valid, 1);
    checkLanes("bp_held");
    start      = 1'b1;
    psum_valid = 1'b1;
    psum_in    = '1;
    tick();
    start      = 1'b0;
    psum_valid = 1'b0;
    checkOutput("bp_stall_start_ready", start_ready, 0);
    checkOutput("bp_stall_psum_ready", psum_ready, 0);
    checkOutput("bp_stall_valid", out_valid, 1);
    checkLanes("bp_stable");
    drainResult();
    checkOutput("bp_refill_valid", out_valid, 1);
    setExp(510);
    checkLanes("bp_second");
    drainResult();
    checkOutput("bp_empty", out_valid, 0);

    $display("[TB] reset mid-operation");
    fillAll(1);
    setExp(255);
    applyStimulus("rmA", 1'b0, 0, 0);
    tick();
    checkOutput("rm_buffer_full", out_valid, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < NCH; c++) psum_in[c*PW +: PW] = 7;
    psum_valid = 1'b1;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rm_out_valid", out_valid, 0);
    checkOutput("rm_nout", (nout == '0), 1);
    checkOutput("rm_bit_idx", bit_idx, 7);
    checkOutput("rm_psum_ready", psum_ready, 0);
    checkOutput("rm_start_ready", start_ready, 1);
    checkOutput("rm_busy", busy, 0);
    psum_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fillAll(2);
    setExp(510);
    applyStimulus("rmB", 1'b0, 0, 0);
    checkLatency("rmB");
    drainResult();

    $display("[TB] extreme negative psum");
    fillAll(-(2**26));
    setExp(-64'sd17112760320);
    applyStimulus("extU", 1'b0, 0, 0);
    checkLatency("extU");
    drainResult();
    setExp(64'sd67108864);
    applyStimulus("extS", 1'b1, 0, 0);
    checkLatency("extS");
    drainResult();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cim_bitserial_accumulator.md
Name: cim_bitserial_accumulator

Overview:
Multi-channel, bit-serial shift-accumulate engine that sits between the global I/O partial-sum outputs and the macro output bus.
- Supersedes the single-channel fixed-width accumulator.
- NCH channels, configurable input-activation precision, MSB-first shift-add with signed-MSB negation.
- Valid/ready handshakes on both sides.
- One-deep result buffer, so the next operation overlaps with output drain.

Parameters:
NCH, 4, number of parallel psum channels (columns)
PSUM_WIDTH, 27, width of one signed psum from global I/O
IN_BITS, 8, activation precision = psum beats per operation (>=2)
ACC_WIDTH, 51, per-channel accumulator width; must be >= PSUM_WIDTH+IN_BITS (no overflow possible, no saturation logic)
BIDX_W, $clog2(IN_BITS), width of bit_idx

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation (sampled only when start_ready=1)
start_ready  out  1  engine can accept start
signed_op  in  1  sampled with start; 1 = activation MSB has weight -2^(IN_BITS-1)
bit_idx  out  BIDX_W  activation bit the array must present for the next psum beat
psum_valid  in  1  psum_in holds a beat
psum_ready  out  1  engine consumes beat this cycle
psum_in  in  NCH*PSUM_WIDTH  packed signed psums, channel c at [c*PSUM_WIDTH +: PSUM_WIDTH]
out_valid  out  1  nout holds a result
out_ready  in  1  downstream accepts result
nout  out  NCH*ACC_WIDTH  packed signed results, same packing rule
busy  out  1  state != IDLE or result buffer full

Behaviour:
- Reset (async, rst_n=0), immediately:
  - state=IDLE; beat counter=0; accumulators=0.
  - out_valid=0; nout=0; bit_idx=IN_BITS-1; psum_ready=0; start_ready=1; busy=0.
  - A reset mid-operation discards the partial result and any buffered result.
- States:
  - IDLE: start_ready=1. start=1 -> capture signed_op, clear all accumulators, bit_idx=IN_BITS-1, go ACC.
  - ACC: psum_ready=1. On each psum_valid&&psum_ready beat, for every channel c:
    - Sign-extend psum_c to ACC_WIDTH.
    - First beat, signed_op=1: acc_c <= -psum_c.
    - First beat, signed_op=0: acc_c <= psum_c.
    - Later beats: acc_c <= (acc_c<<1) + psum_c.
    - bit_idx decrements after each beat.
    - After the IN_BITS-th beat go DRAIN. No bubbles required: IN_BITS back-to-back beats complete in IN_BITS cycles.
  - DRAIN: psum_ready=0.
    - Result buffer empty, or emptied this same cycle (out_valid&&out_ready): copy acc to nout, set out_valid=1, go IDLE.
    - Otherwise stall in DRAIN.
- Timing:
  - Latency: last beat accepted in cycle N -> out_valid=1 in cycle N+2.
  - Result buffer:
    - out_valid stays 1 and nout stays stable until out_ready=1.
    - Clears on handshake unless refilled in the same cycle (refill wins, out_valid stays 1).
- Boundary conditions:
  - start while not in IDLE is ignored.
  - psum_valid while psum_ready=0 is not consumed.
  - start is accepted in IDLE even while the result buffer is full (overlap).
  - bit_idx holds at 0 after the final beat, then reloads to IN_BITS-1 on the next accepted start.
  - signed_op changes mid-operation are ignored.
  - psum is always treated as signed two's complement; global I/O guarantees this.

Decomposition:
- Shared package cim_pkg: ACC_WIDTH-vs-PSUM_WIDTH+IN_BITS legality constant, state encoding (IDLE/ACC/DRAIN) and its localparam width, packing-index helper function.
- One natural sub-module, cim_shift_acc_lane: a single-channel shift-add lane with first/signed control, instantiated NCH times by generate.
- The FSM, beat counter and result buffer live in the top.

Test Plan:
- Unsigned, NCH=4, IN_BITS=8: eight back-to-back beats, psum_c=1 every beat on all channels -> out_valid 2 cycles after the last beat, each lane nout=255.
- Signed: beats MSB-first psum = 1,0,0,0,0,0,0,0 -> nout=-128 per lane. Psum -3 on MSB beat then 0s -> +384.
- Back-pressure: out_ready=0; a second operation completes -> engine stalls in DRAIN with first result held stable. Raise out_ready one cycle -> first result accepted, second loaded the same cycle, out_valid never drops.
- psum_valid gaps: insert 3 idle cycles between beats 2 and 3 -> result identical to the gap-free case; bit_idx sequence is exactly 7..0.
- Reset mid-op: assert rst_n=0 after beat 4 -> all outputs at reset values asynchronously. After release, a new operation with psum=2 every beat (unsigned) -> nout=510, with no residue from the aborted operation.
- Extreme width: psum=-(2^26) on all beats, signed_op=0 -> nout=-(2^26)*255, and no wrap at ACC_WIDTH=51.
